// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } sched_state_e;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_BUSY_TMO = 4;

  // Reduce v into [0, n) when v is known to be below 2n.
  function automatic int unsigned wrap_idx(input int unsigned v, input int unsigned n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter signals of the scheduler; master is the scheduler side.
interface uart_tx_sched_if
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) ();

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   cfg_par_en;
  logic [NUM_REQ-1:0]   cfg_par_typ;
  logic [7:0]           P_DATA;
  logic                 DATA_valid;
  logic                 PAR_EN;
  logic                 PAR_TYP;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic                 tx_done;
  logic                 tmo_err;

  modport master (
    input  req_valid, req_data, cfg_par_en, cfg_par_typ, busy,
    output req_ready, P_DATA, DATA_valid, PAR_EN, PAR_TYP, grant_id, tx_done, tmo_err
  );

  modport slave (
    output req_valid, req_data, cfg_par_en, cfg_par_typ, busy,
    input  req_ready, P_DATA, DATA_valid, PAR_EN, PAR_TYP, grant_id, tx_done, tmo_err
  );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     idx
);

  always_comb begin
    logic           found;
    logic [IDW-1:0] sel;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sel = IDW'(wrap_idx(int'(ptr) + i, NUM_REQ));
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ requesters with round-robin grant,
// per-requester parity config and a busy-rise timeout.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned BUSY_TMO = DEF_BUSY_TMO
) (
  input logic            clk,
  input logic            rst,
  uart_tx_sched_if.master bus
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  sched_state_e state, state_nxt;

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic [7:0]         win_byte;
  logic [IDW-1:0]     lat_id;
  logic [7:0]         lat_data;
  logic               lat_pen;
  logic               lat_ptyp;
  logic [7:0]         cnt;

  logic grant_fire;
  logic issue;
  logic done;
  logic tmo;
  logic holding;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == win_idx) win_byte = bus.req_data[i*8 +: 8];
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    issue      = 1'b0;
    done       = 1'b0;
    tmo        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.busy && (|bus.req_valid)) begin
          grant_fire = 1'b1;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue     = 1'b1;
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.busy) begin
          state_nxt = S_WAIT_DONE;
        end else if (cnt >= 8'(BUSY_TMO)) begin
          tmo       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.busy) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      lat_id   <= '0;
      lat_data <= '0;
      lat_pen  <= 1'b0;
      lat_ptyp <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_fire) begin
        lat_id   <= win_idx;
        lat_data <= win_byte;
        lat_pen  <= bus.cfg_par_en[win_idx];
        lat_ptyp <= bus.cfg_par_typ[win_idx];
        ptr      <= (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      if (state == S_ISSUE) begin
        cnt <= '0;
      end else if (state == S_WAIT_BUSY) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Outputs are forced low while rst is high, even before the state register clears.
  assign holding = (state != S_IDLE) && !rst;

  assign bus.req_ready  = (grant_fire && !rst) ? win_gnt : '0;
  assign bus.DATA_valid = issue && !rst;
  assign bus.tx_done    = done && !rst;
  assign bus.tmo_err    = tmo && !rst;
  assign bus.P_DATA     = holding ? lat_data : '0;
  assign bus.PAR_EN     = holding && lat_pen;
  assign bus.PAR_TYP    = holding && lat_ptyp;
  assign bus.grant_id   = holding ? lat_id : '0;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with NUM_REQ=4, BUSY_TMO=4.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_sched_if #(.NUM_REQ(4)) bus ();

  uart_tx_sched #(.NUM_REQ(4), .BUSY_TMO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in S_IDLE with the winner's request already driven; ends in the following S_IDLE.
  task automatic do_frame(input int unsigned id, input logic [7:0] data, input string tag);
    #1;
    check({tag, ".ready"}, 32'(bus.req_ready), 32'(1) << id);
    step();
    #1;
    check({tag, ".dv"},    32'(bus.DATA_valid), 32'd1);
    check({tag, ".gid"},   32'(bus.grant_id), 32'(id));
    check({tag, ".pdata"}, 32'(bus.P_DATA), 32'(data));
    step();
    bus.busy = 1'b1;
    #1;
    check({tag, ".nodone_wb"}, 32'(bus.tx_done), 32'd0);
    step();
    bus.busy = 1'b0;
    #1;
    check({tag, ".done"}, 32'(bus.tx_done), 32'd1);
    step();
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_valid   = '0;
    bus.req_data    = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.cfg_par_en  = '0;
    bus.cfg_par_typ = '0;
    bus.busy        = 1'b0;

    step();
    #1;
    check("rst.ready", 32'(bus.req_ready), 32'd0);
    check("rst.dv",    32'(bus.DATA_valid), 32'd0);
    check("rst.pdata", 32'(bus.P_DATA), 32'd0);
    check("rst.gid",   32'(bus.grant_id), 32'd0);
    check("rst.flags", {28'd0, bus.PAR_EN, bus.PAR_TYP, bus.tx_done, bus.tmo_err}, 32'd0);

    // Single request from requester 2
    rst                  = 1'b0;
    bus.req_data[23:16]  = 8'hA5;
    bus.cfg_par_en       = 4'b0100;
    bus.req_valid        = 4'b0100;
    #1;
    check("single.ready", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = '0;
    #1;
    check("single.dv",    32'(bus.DATA_valid), 32'd1);
    check("single.pdata", 32'(bus.P_DATA), 32'hA5);
    check("single.paren", 32'(bus.PAR_EN), 32'd1);
    check("single.partyp", 32'(bus.PAR_TYP), 32'd0);
    check("single.gid",   32'(bus.grant_id), 32'd2);
    check("single.ready_off", 32'(bus.req_ready), 32'd0);
    step();
    bus.busy = 1'b1;
    #1;
    check("single.dv_once", 32'(bus.DATA_valid), 32'd0);
    step();
    #1;
    check("single.nodone_busy", 32'(bus.tx_done), 32'd0);
    bus.busy = 1'b0;
    #1;
    check("single.done",  32'(bus.tx_done), 32'd1);
    check("single.hold",  32'(bus.P_DATA), 32'hA5);
    step();
    #1;
    check("single.idle_pdata", 32'(bus.P_DATA), 32'd0);
    check("single.idle_done",  32'(bus.tx_done), 32'd0);

    // Round-robin with all four requesting, from ptr=0
    rst = 1'b1;
    bus.req_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.cfg_par_en = '0;
    step();
    rst           = 1'b0;
    bus.req_valid = 4'hF;
    do_frame(0, 8'h10, "rr0");
    do_frame(1, 8'h11, "rr1");
    do_frame(2, 8'h12, "rr2");
    do_frame(3, 8'h13, "rr3");
    do_frame(0, 8'h10, "rr4");
    bus.req_valid = '0;

    // Busy never rises: timeout
    step();
    bus.req_valid = 4'b0010;
    #1;
    check("tmo.ready", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = '0;
    step();
    #1;
    check("tmo.entry", 32'(bus.tmo_err), 32'd0);
    for (int unsigned k = 1; k < 4; k++) begin
      step();
      #1;
      check("tmo.early", 32'(bus.tmo_err), 32'd0);
    end
    step();
    #1;
    check("tmo.pulse",  32'(bus.tmo_err), 32'd1);
    check("tmo.nodone", 32'(bus.tx_done), 32'd0);
    step();
    #1;
    check("tmo.once",       32'(bus.tmo_err), 32'd0);
    check("tmo.idle_pdata", 32'(bus.P_DATA), 32'd0);
    check("tmo.idle_dv",    32'(bus.DATA_valid), 32'd0);
    bus.req_valid = 4'b1000;
    do_frame(3, 8'h13, "tmo_next");
    bus.req_valid = '0;

    // Config and data changes after acceptance do not reach the frame in flight
    bus.req_data[15:8] = 8'h3C;
    bus.cfg_par_en     = 4'b0010;
    bus.cfg_par_typ    = 4'b0010;
    bus.req_valid      = 4'b0010;
    #1;
    check("lat.ready", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid      = '0;
    bus.req_data[15:8] = 8'hFF;
    bus.cfg_par_typ    = '0;
    bus.cfg_par_en     = '0;
    #1;
    check("lat.issue_pdata",  32'(bus.P_DATA), 32'h3C);
    check("lat.issue_partyp", 32'(bus.PAR_TYP), 32'd1);
    check("lat.issue_paren",  32'(bus.PAR_EN), 32'd1);
    step();
    bus.busy = 1'b1;
    #1;
    check("lat.wb_pdata",  32'(bus.P_DATA), 32'h3C);
    check("lat.wb_partyp", 32'(bus.PAR_TYP), 32'd1);
    step();
    bus.busy = 1'b0;
    #1;
    check("lat.done",        32'(bus.tx_done), 32'd1);
    check("lat.done_pdata",  32'(bus.P_DATA), 32'h3C);
    check("lat.done_partyp", 32'(bus.PAR_TYP), 32'd1);
    step();
    #1;
    check("lat.idle_partyp", 32'(bus.PAR_TYP), 32'd0);

    // Transmitter busy while idle blocks grants
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.busy      = 1'b1;
    bus.req_valid = 4'b0001;
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      check("bsyidle.ready", 32'(bus.req_ready), 32'd0);
      check("bsyidle.dv",    32'(bus.DATA_valid), 32'd0);
      step();
    end
    bus.busy = 1'b0;
    do_frame(0, 8'h10, "bsyidle");
    bus.req_valid = '0;

    // Reset during S_WAIT_DONE abandons the frame and clears ptr
    bus.req_valid = 4'b0100;
    #1;
    check("rstmid.ready", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = '0;
    step();
    bus.busy = 1'b1;
    step();
    #1;
    check("rstmid.wd_pdata", 32'(bus.P_DATA), 32'h12);
    rst = 1'b1;
    #1;
    check("rstmid.during_pdata", 32'(bus.P_DATA), 32'd0);
    check("rstmid.during_gid",   32'(bus.grant_id), 32'd0);
    step();
    rst      = 1'b0;
    bus.busy = 1'b0;
    #1;
    check("rstmid.after_pdata", 32'(bus.P_DATA), 32'd0);
    check("rstmid.after_done",  32'(bus.tx_done), 32'd0);
    check("rstmid.after_flags", {29'd0, bus.DATA_valid, bus.tmo_err, bus.PAR_EN}, 32'd0);
    for (int unsigned k = 0; k < 2; k++) begin
      step();
      #1;
      check("rstmid.noreplay", {30'd0, bus.DATA_valid, bus.tx_done}, 32'd0);
    end
    bus.req_valid = 4'hF;
    do_frame(0, 8'h10, "rstmid_next");
    bus.req_valid = '0;

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
